// File: rtl/max1271_resp_pkg.sv
// rtl/max1271_resp_pkg.sv - shared states and frame constants for the MAX1271 responder.
package max1271_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    CTRL,
    ACQ,
    SHIFT,
    TAIL
  } state_t;

  localparam int         CTRL_BITS = 8;
  localparam int         DATA_BITS = 12;
  localparam int         START_POS = 7;
  localparam logic [1:0] PD_OFF    = 2'b00;

endpackage

// File: rtl/max1271_resp_sync_edge.sv
// rtl/max1271_resp_sync_edge.sv - multi-stage synchronizer with rise/fall detection on the synced level.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      prev  <= chain[STAGES-1];
    end
  end

  // Edges are decoded combinationally so downstream registers land one cycle later.
  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/max1271_resp.sv
// rtl/max1271_resp.sv - MAX1271 ADC slave emulator: takes the control byte, fetches a sample, shifts it out.
// MAX1271_RESP_BIPOLAR_EN: when defined, BIP=1 flips the result MSB (offset binary to two's complement).
module max1271_resp
  import max1271_resp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ACQ_CLKS    = 1
) (
  input  logic        FASTCLK,
  input  logic        RST_B,
  input  logic        ADC_SCLK,
  input  logic        ADC_CS_B,
  input  logic        ADC_DIN,
  output logic        ADC_DOUT,
  output logic        SAMPLE_REQ,
  output logic [2:0]  CHAN,
  input  logic        SAMPLE_ACK,
  input  logic [11:0] SAMPLE,
  output logic [7:0]  CTRL_BYTE,
  output logic        FRAME_DONE,
  output logic        ERR
);

  localparam logic [3:0] CTRL_LAST = 4'(START_POS - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [1:0] ACQ_LAST  = 2'(ACQ_CLKS - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic din_lvl, din_rise, din_fall;
  logic unused_edges;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(FASTCLK), .rst_n(RST_B), .pin(ADC_SCLK),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(FASTCLK), .rst_n(RST_B), .pin(ADC_CS_B),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
    .clk(FASTCLK), .rst_n(RST_B), .pin(ADC_DIN),
    .level(din_lvl), .rise(din_rise), .fall(din_fall)
  );

  assign unused_edges = ^{sclk_lvl, cs_rise, cs_fall, din_rise, din_fall};

  state_t                     state, state_nx;
  logic [3:0]                 bit_cnt, bit_cnt_nx;
  logic [1:0]                 acq_cnt, acq_cnt_nx;
  logic [CTRL_BITS-3:0]       ctrl_sh, ctrl_sh_nx;
  logic [CTRL_BITS-2:0]       ctrl_full;
  logic [DATA_BITS-1:0]       result, result_nx;
  logic                       acked, acked_nx, ack_now;
  logic                       dout_nx, req_nx, done_nx, err_nx;
  logic [2:0]                 chan_nx;
  logic [7:0]                 ctrl_byte_nx;
  logic                       msb_flip;

`ifdef MAX1271_RESP_BIPOLAR_EN
  assign msb_flip = CTRL_BYTE[2];
`else
  assign msb_flip = 1'b0;
`endif

  always_ff @(posedge FASTCLK or negedge RST_B) begin
    if (!RST_B) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      acq_cnt    <= '0;
      ctrl_sh    <= '0;
      result     <= '0;
      acked      <= 1'b0;
      ADC_DOUT   <= 1'b0;
      SAMPLE_REQ <= 1'b0;
      CHAN       <= '0;
      CTRL_BYTE  <= 8'h00;
      FRAME_DONE <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      acq_cnt    <= acq_cnt_nx;
      ctrl_sh    <= ctrl_sh_nx;
      result     <= result_nx;
      acked      <= acked_nx;
      ADC_DOUT   <= dout_nx;
      SAMPLE_REQ <= req_nx;
      CHAN       <= chan_nx;
      CTRL_BYTE  <= ctrl_byte_nx;
      FRAME_DONE <= done_nx;
      ERR        <= err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    acq_cnt_nx   = acq_cnt;
    ctrl_sh_nx   = ctrl_sh;
    result_nx    = result;
    acked_nx     = acked;
    dout_nx      = ADC_DOUT;
    req_nx       = SAMPLE_REQ;
    chan_nx      = CHAN;
    ctrl_byte_nx = CTRL_BYTE;
    done_nx      = 1'b0;
    err_nx       = 1'b0;
    ack_now      = 1'b0;
    ctrl_full    = {ctrl_sh, din_lvl};

    // Deasserted chip select overrides every state, including a coincident SCLK edge.
    if (cs_lvl) begin
      state_nx = IDLE;
      req_nx   = 1'b0;
      dout_nx  = 1'b0;
    end else begin
      case (state)
        IDLE: state_nx = HUNT;
        HUNT: begin
          if (sclk_rise && din_lvl) begin
            state_nx   = CTRL;
            bit_cnt_nx = '0;
          end
        end
        CTRL: begin
          if (sclk_rise) begin
            ctrl_sh_nx = ctrl_full[CTRL_BITS-3:0];
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == CTRL_LAST) begin
              ctrl_byte_nx = {1'b1, ctrl_full};
              if (ctrl_full[1:0] == PD_OFF) begin
                state_nx = TAIL;
              end else begin
                state_nx   = ACQ;
                chan_nx    = ctrl_full[6:4];
                acq_cnt_nx = '0;
                acked_nx   = 1'b0;
              end
            end
          end
        end
        ACQ: begin
          dout_nx = 1'b0;
          if (SAMPLE_REQ && SAMPLE_ACK) begin
            ack_now   = 1'b1;
            acked_nx  = 1'b1;
            req_nx    = 1'b0;
            result_nx = {SAMPLE[DATA_BITS-1] ^ msb_flip, SAMPLE[DATA_BITS-2:0]};
          end else if (!acked) begin
            req_nx = 1'b1;
          end
          if (sclk_fall) begin
            acq_cnt_nx = acq_cnt + 2'd1;
            if (acq_cnt == ACQ_LAST) begin
              state_nx   = SHIFT;
              bit_cnt_nx = '0;
              req_nx     = 1'b0;
              if (!acked && !ack_now) begin
                result_nx = '1;
                err_nx    = 1'b1;
              end
            end
          end
        end
        SHIFT: begin
          if (sclk_fall) begin
            dout_nx    = result[DATA_BITS-1];
            result_nx  = {result[DATA_BITS-2:0], 1'b0};
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == DATA_LAST) begin
              done_nx  = 1'b1;
              state_nx = TAIL;
            end
          end
        end
        // The last result bit is held until the master's next falling edge, then the line idles low.
        TAIL: begin
          if (sclk_fall) dout_nx = 1'b0;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: doc/max1271_resp.md
MAX1271_RESP -- requirements
Module: max1271_resp

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on ADC_SCLK, ADC_CS_B and ADC_DIN (min 2).
REQ-002 SHALL have parameter ACQ_CLKS, default 1: number of ADC_SCLK falling edges after the control byte that drive 0 before the result MSB (1..4).
REQ-003 SHALL have port FASTCLK  in  1  sole clock; all state is updated on its rising edge.
REQ-004 SHALL have port RST_B  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ADC_SCLK  in  1  serial clock from the ADC master, asynchronous to FASTCLK.
REQ-006 SHALL have port ADC_CS_B  in  1  chip select, active-low, asynchronous.
REQ-007 SHALL have port ADC_DIN  in  1  serial control data from the master, MSB first.
REQ-008 SHALL have port ADC_DOUT  out  1  serial conversion result to the master.
REQ-009 SHALL have port SAMPLE_REQ  out  1  level request for a conversion value.
REQ-010 SHALL have port CHAN  out  3  channel (SEL2..0) of the current request.
REQ-011 SHALL have port SAMPLE_ACK  in  1  sample-source acknowledge.
REQ-012 SHALL have port SAMPLE  in  12  conversion value, valid with SAMPLE_ACK.
REQ-013 SHALL have port CTRL_BYTE  out  8  last complete control byte received.
REQ-014 SHALL have port FRAME_DONE  out  1  one-cycle pulse when the 12th result bit has been driven.
REQ-015 SHALL have port ERR  out  1  one-cycle pulse on a missed sample handshake.

Function
REQ-016 SHALL detect ADC_SCLK rise/fall edges on the synchronized signal; the master guarantees SCLK high and low phases of at least SYNC_STAGES+2 FASTCLK cycles each.
REQ-017 SHALL implement states IDLE, HUNT, CTRL, ACQ, SHIFT and TAIL.
REQ-018 IDLE->HUNT when synchronized CS_B is low; any state->IDLE within one cycle of synchronized CS_B high (frame abort, no FRAME_DONE, SAMPLE_REQ dropped).
REQ-019 HUNT: on each SCLK rise, DIN=1 is the START bit -> CTRL; DIN=0 is ignored.
REQ-020 CTRL: the next 7 SCLK rises shift in SEL2..0, RNG, BIP, PD1, PD0; after the 7th rise, CTRL_BYTE shall be loaded with {1, 7 bits}.
REQ-021 If PD1:PD0 = 00 after CTRL, the block SHALL go to TAIL with no request; otherwise it SHALL go to ACQ, assert SAMPLE_REQ one cycle later, and drive CHAN = SEL2..0.
REQ-022 SAMPLE_REQ SHALL stay high until the cycle SAMPLE_ACK is seen high; SAMPLE SHALL be latched in that cycle, and SAMPLE_REQ SHALL drop the next cycle.
REQ-023 ACQ SHALL count ACQ_CLKS SCLK falls while driving ADC_DOUT=0, then go to SHIFT.
REQ-024 If no ACK has arrived by ACQ exit, the latched value SHALL be 12'hFFF, ERR SHALL pulse once, and SAMPLE_REQ SHALL drop; an ACK arriving later SHALL be ignored.
REQ-025 SHIFT: on each SCLK fall, ADC_DOUT SHALL present the next result bit, MSB first, within SYNC_STAGES+1 FASTCLK cycles of the pin edge.
REQ-026 After the 12th bit is presented, FRAME_DONE SHALL pulse and the state SHALL go to TAIL.
REQ-027 TAIL SHALL drive ADC_DOUT=0 and ignore SCLK until CS_B is high.
REQ-028 A new START bit SHALL only be accepted after CS_B has gone high and then low again.
REQ-029 If an SCLK edge and a CS_B rise are detected in the same cycle, the CS_B rise wins.

Reset
REQ-030 On RST_B low: state IDLE, ADC_DOUT=0, SAMPLE_REQ=0, CHAN=0, CTRL_BYTE=8'h00, FRAME_DONE=0, ERR=0, synchronizers cleared to CS_B=1, SCLK=0, DIN=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; after release, the block SHALL wait for a CS_B high-to-low transition before hunting.

Configuration
REQ-032 With MAX1271_RESP_BIPOLAR_EN defined and BIP=1, the block SHALL invert the MSB of the latched value before shifting (offset binary to two's complement).
REQ-033 Without MAX1271_RESP_BIPOLAR_EN, BIP SHALL be stored in CTRL_BYTE but SHALL NOT alter the result.

Structure
REQ-034 Package max1271_resp_pkg SHALL hold the state enum and the constants CTRL_BITS=8, DATA_BITS=12, START_POS=7 and PD_OFF=2'b00.
REQ-035 Synchronization and edge detection SHALL be one sub-module, sync_edge, instantiated for SCLK and CS_B; DIN SHALL use its synchronizer-only output.

Verification
REQ-036 CS_B low, DIN=8'b1_011_0_0_01, ACK with SAMPLE=12'hA5C before ACQ exit -> CHAN=3, CTRL_BYTE=8'hB1, DOUT=0 then 1010_0101_1100, FRAME_DONE once.
REQ-037 Same frame with no ACK -> DOUT=12 ones, ERR pulse once, SAMPLE_REQ low after ACQ.
REQ-038 Control byte 8'h80 (PD=00) -> no SAMPLE_REQ, DOUT stays 0, no FRAME_DONE.
REQ-039 Three leading zero bits then 8'hF3 -> zeros ignored, CTRL_BYTE=8'hF3, CHAN=7.
REQ-040 CS_B raised after result bit 5 -> IDLE, no FRAME_DONE; next frame completes normally; RST_B pulsed during SHIFT -> all outputs at reset values.
REQ-041 MAX1271_RESP_BIPOLAR_EN defined, BIP=1, SAMPLE=12'h800 -> DOUT 12'h000; BIP=0 -> 12'h800.
